// File: rtl/tetris_mem_pkg.sv
// Shared defaults and port encodings for the on-chip RAM arbiter.
package tetris_mem_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W_DEF   = 2;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_GFX = 1'b1
  } port_e;

endpackage

// File: rtl/tetris_mem_arb_grant.sv
// Combinational grant decision for the two-port RAM arbiter.
// ONCHIP_ARB_PRIO_EN: port 1 wins ties until it has starved port 0 PRIO_LIMIT times.
module tetris_mem_arb_grant
  import tetris_mem_pkg::*;
#(
  parameter int PRIO_LIMIT = 4,
  parameter int CNT_W      = $clog2(PRIO_LIMIT + 1)
) (
  input  logic             req_cpu,
  input  logic             req_gfx,
  input  port_e            last_grant,
`ifdef ONCHIP_ARB_PRIO_EN
  input  logic [CNT_W-1:0] prio_cnt,
`endif
  output logic             gnt_valid,
  output port_e            gnt_port
);

  always_comb begin
    gnt_valid = req_cpu | req_gfx;
    gnt_port  = PORT_CPU;
    if (req_cpu && req_gfx) begin
`ifdef ONCHIP_ARB_PRIO_EN
      gnt_port = (prio_cnt >= CNT_W'(PRIO_LIMIT)) ? PORT_CPU : PORT_GFX;
`else
      gnt_port = (last_grant == PORT_CPU) ? PORT_GFX : PORT_CPU;
`endif
    end else if (req_gfx) begin
      gnt_port = PORT_GFX;
    end
  end

endmodule

// File: rtl/tetris_nios_onchip_mem_arbiter.sv
// Two Avalon-style masters sharing one single-port RAM with 1-cycle read latency.
// ONCHIP_ARB_PRIO_EN selects bounded port-1 priority instead of round-robin.
module tetris_nios_onchip_mem_arbiter
  import tetris_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BE_W       = BE_W_DEF,
  parameter int PRIO_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int CNT_W = $clog2(PRIO_LIMIT + 1);

  // Handshake: a master holds read/write until it sees waitrequest=0 in the
  // same cycle; that cycle is the accept. Reads answer with a one-cycle
  // readdatavalid pulse exactly one cycle after accept; writes never answer.

  logic  req_cpu, req_gfx;
  logic  gnt_valid, gnt_write;
  port_e gnt_port, last_grant;
  logic  rd_pend;
  port_e rd_port;

  // Requests are masked during reset so nothing reaches the RAM.
  assign req_cpu = reset_n & (p0_read | p0_write);
  assign req_gfx = reset_n & (p1_read | p1_write);

`ifdef ONCHIP_ARB_PRIO_EN
  logic [CNT_W-1:0] prio_cnt;
`endif

  tetris_mem_arb_grant #(
    .PRIO_LIMIT (PRIO_LIMIT),
    .CNT_W      (CNT_W)
  ) u_grant (
    .req_cpu    (req_cpu),
    .req_gfx    (req_gfx),
    .last_grant (last_grant),
`ifdef ONCHIP_ARB_PRIO_EN
    .prio_cnt   (prio_cnt),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_port   (gnt_port)
  );

  always_comb begin
    mem_address    = p0_address;
    mem_writedata  = p0_writedata;
    gnt_write      = p0_write;
    mem_byteenable = p0_byteenable;
    if (gnt_port == PORT_GFX) begin
      mem_address    = p1_address;
      mem_writedata  = p1_writedata;
      gnt_write      = p1_write;
      mem_byteenable = p1_byteenable;
    end
    // Reads always fetch the full word.
    if (!gnt_write) mem_byteenable = {BE_W{1'b1}};
    mem_chipselect = gnt_valid;
    mem_write      = gnt_valid & gnt_write;
    mem_clken      = reset_n;
    p0_waitrequest = !(gnt_valid && gnt_port == PORT_CPU);
    p1_waitrequest = !(gnt_valid && gnt_port == PORT_GFX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_GFX;
      rd_pend    <= 1'b0;
      rd_port    <= PORT_CPU;
    end else begin
      if (gnt_valid) last_grant <= gnt_port;
      rd_pend <= gnt_valid & ~gnt_write;
      rd_port <= gnt_port;
    end
  end

`ifdef ONCHIP_ARB_PRIO_EN
  // Counts port-1 wins while port 0 is kept waiting; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_cnt <= '0;
    end else if (!req_cpu || (gnt_valid && gnt_port == PORT_CPU)) begin
      prio_cnt <= '0;
    end else if (gnt_valid && gnt_port == PORT_GFX && prio_cnt < CNT_W'(PRIO_LIMIT)) begin
      prio_cnt <= prio_cnt + CNT_W'(1);
    end
  end
`endif

  assign p0_readdata      = mem_readdata;
  assign p1_readdata      = mem_readdata;
  assign p0_readdatavalid = rd_pend && rd_port == PORT_CPU;
  assign p1_readdatavalid = rd_pend && rd_port == PORT_GFX;

endmodule

// File: tb/tb_tetris_nios_onchip_mem_arbiter.sv
// Directed bench for tetris_nios_onchip_mem_arbiter with a behavioural 1-cycle RAM.
module tb_tetris_nios_onchip_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] p0_address, p1_address;
  logic [BE_W-1:0]   p0_byteenable, p1_byteenable;
  logic              p0_read, p0_write, p1_read, p1_write;
  logic [DATA_W-1:0] p0_writedata, p1_writedata;
  logic              p0_waitrequest, p1_waitrequest;
  logic [DATA_W-1:0] p0_readdata, p1_readdata;
  logic              p0_readdatavalid, p1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_readdata = '0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  tetris_nios_onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .PRIO_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable),
    .p0_read(p0_read), .p0_write(p0_write), .p0_writedata(p0_writedata),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
    .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable),
    .p1_read(p1_read), .p1_write(p1_write), .p1_writedata(p1_writedata),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
    .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Single-port RAM model: registered read, byte-lane writes.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_ports();
    p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p0_drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    p0_read = rd; p0_write = wr; p0_address = a; p0_byteenable = be; p0_writedata = d;
  endtask

  task automatic p1_drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    p1_read = rd; p1_write = wr; p1_address = a; p1_byteenable = be; p1_writedata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    ram[17'h00010] = 16'hA010;
    ram[17'h00020] = 16'hB020;
    ram[17'h00100] = 16'h1234;
    ram[17'h1FFFF] = 16'h5A5A;

    // Reset behaviour with a request already present
    idle_ports();
    p0_drive(1'b1, 1'b0, 17'h00010, 2'b11, 16'h0000);
    p1_drive(1'b1, 1'b0, 17'h00020, 2'b11, 16'h0000);
    reset_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check_eq("rst_p0_wait", p0_waitrequest, 1'b1);
    check_eq("rst_p1_wait", p1_waitrequest, 1'b1);
    check_eq("rst_p0_rdv", p0_readdatavalid, 1'b0);
    check_eq("rst_p1_rdv", p1_readdatavalid, 1'b0);
    check_eq("rst_cs", mem_chipselect, 1'b0);
    check_eq("rst_wr", mem_write, 1'b0);
    check_eq("rst_clken", mem_clken, 1'b0);
    step();
    idle_ports();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check_eq("idle_cs", mem_chipselect, 1'b0);
    check_eq("idle_clken", mem_clken, 1'b1);
    step();

`ifndef ONCHIP_ARB_PRIO_EN
    // Both ports reading continuously: grants alternate 0,1,0,1...
    p0_drive(1'b1, 1'b0, 17'h00010, 2'b00, 16'h0000);
    p1_drive(1'b1, 1'b0, 17'h00020, 2'b00, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k % 2;
      @(negedge clk);
      check_eq($sformatf("rr_p0_wait_%0d", k), p0_waitrequest, (g != 0));
      check_eq($sformatf("rr_p1_wait_%0d", k), p1_waitrequest, (g != 1));
      check_eq($sformatf("rr_addr_%0d", k), mem_address, (g == 0) ? 17'h00010 : 17'h00020);
      check_eq($sformatf("rr_be_%0d", k), mem_byteenable, 2'b11);
      if (k > 0) begin
        check_eq($sformatf("rr_p0_rdv_%0d", k), p0_readdatavalid, (g == 1));
        check_eq($sformatf("rr_p1_rdv_%0d", k), p1_readdatavalid, (g == 0));
        check_eq($sformatf("rr_data_%0d", k), (g == 1) ? p0_readdata : p1_readdata,
                 exp_q.pop_front());
      end
      exp_q.push_back((g == 0) ? 16'hA010 : 16'hB020);
      step();
    end
    idle_ports();
    @(negedge clk);
    check_eq("rr_last_p1_rdv", p1_readdatavalid, 1'b1);
    check_eq("rr_last_data", p1_readdata, exp_q.pop_front());
    step();
`else
    // Bounded priority: port 1 wins four ties, then port 0 once.
    begin
      int pat [5];
      pat = '{1, 1, 1, 1, 0};
      p0_drive(1'b1, 1'b0, 17'h00010, 2'b00, 16'h0000);
      p1_drive(1'b1, 1'b0, 17'h00020, 2'b00, 16'h0000);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check_eq($sformatf("pr_p0_wait_%0d", k), p0_waitrequest, (pat[k % 5] != 0));
        check_eq($sformatf("pr_p1_wait_%0d", k), p1_waitrequest, (pat[k % 5] != 1));
        step();
      end
      idle_ports();
      step();
    end
`endif

    // Byte-lane write then read-back of the merged word
    p0_drive(1'b0, 1'b1, 17'h00100, 2'b01, 16'hBEEF);
    @(negedge clk);
    check_eq("wr_p0_wait", p0_waitrequest, 1'b0);
    check_eq("wr_mem_write", mem_write, 1'b1);
    check_eq("wr_be", mem_byteenable, 2'b01);
    check_eq("wr_data", mem_writedata, 16'hBEEF);
    step();
    p0_drive(1'b1, 1'b0, 17'h00100, 2'b01, 16'h0000);
    @(negedge clk);
    check_eq("wr_no_rdv", p0_readdatavalid, 1'b0);
    check_eq("rb_p0_wait", p0_waitrequest, 1'b0);
    check_eq("rb_mem_write", mem_write, 1'b0);
    check_eq("rb_be", mem_byteenable, 2'b11);
    step();
    idle_ports();
    @(negedge clk);
    check_eq("rb_rdv", p0_readdatavalid, 1'b1);
    check_eq("rb_data", p0_readdata, 16'h12EF);
    check_eq("rb_p1_rdv", p1_readdatavalid, 1'b0);
    step();

    // Single port-1 read at the top address
    p1_drive(1'b1, 1'b0, 17'h1FFFF, 2'b00, 16'h0000);
    @(negedge clk);
    check_eq("p1_wait", p1_waitrequest, 1'b0);
    check_eq("p1_p0_wait_idle", p0_waitrequest, 1'b1);
    check_eq("p1_addr", mem_address, 17'h1FFFF);
    step();
    idle_ports();
    @(negedge clk);
    check_eq("p1_rdv", p1_readdatavalid, 1'b1);
    check_eq("p1_data", p1_readdata, 16'h5A5A);
    check_eq("p1_p0_rdv", p0_readdatavalid, 1'b0);
    step();
    @(negedge clk);
    check_eq("p1_rdv_once", p1_readdatavalid, 1'b0);
    check_eq("p1_p0_rdv_after", p0_readdatavalid, 1'b0);
    step();

    // Read and write together is a write
    p0_drive(1'b1, 1'b1, 17'h00040, 2'b11, 16'h7777);
    @(negedge clk);
    check_eq("rw_mem_write", mem_write, 1'b1);
    check_eq("rw_p0_wait", p0_waitrequest, 1'b0);
    step();
    idle_ports();
    @(negedge clk);
    check_eq("rw_no_rdv", p0_readdatavalid, 1'b0);
    check_eq("rw_ram", ram[17'h00040], 16'h7777);
    step();

    // Reset pulse right after a read accept drops the pending response
    p0_drive(1'b1, 1'b0, 17'h00010, 2'b00, 16'h0000);
    @(negedge clk);
    check_eq("rp_accept", p0_waitrequest, 1'b0);
    step();
    idle_ports();
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("rp_p0_rdv_in", p0_readdatavalid, 1'b0);
    check_eq("rp_p1_rdv_in", p1_readdatavalid, 1'b0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rp_p0_rdv_out", p0_readdatavalid, 1'b0);
    check_eq("rp_p1_rdv_out", p1_readdatavalid, 1'b0);
    step();
    p0_drive(1'b1, 1'b0, 17'h00010, 2'b00, 16'h0000);
    p1_drive(1'b1, 1'b0, 17'h00020, 2'b00, 16'h0000);
    @(negedge clk);
`ifndef ONCHIP_ARB_PRIO_EN
    check_eq("rp_tie_p0_wait", p0_waitrequest, 1'b0);
    check_eq("rp_tie_p1_wait", p1_waitrequest, 1'b1);
    step();
    idle_ports();
    @(negedge clk);
    check_eq("rp_tie_rdv", p0_readdatavalid, 1'b1);
    check_eq("rp_tie_data", p0_readdata, 16'hA010);
`else
    check_eq("rp_tie_p0_wait", p0_waitrequest, 1'b1);
    check_eq("rp_tie_p1_wait", p1_waitrequest, 1'b0);
    step();
    idle_ports();
    @(negedge clk);
    check_eq("rp_tie_rdv", p1_readdatavalid, 1'b1);
    check_eq("rp_tie_data", p1_readdata, 16'hB020);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
